// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an A5-framed image over 8N1 serial and writes it word by word into IMEM.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte before the core is released.
`timescale 1ns/1ps
module uart_boot_loader #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        boot_done,
    output logic        boot_err
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_C = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] LAST_C = CW'(DIV - 1);
    localparam logic [31:0]   MAXW_C = 32'(IMEM_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {SYNC, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {SYNC, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
`endif

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            byte_valid_s, frame_err_s;

    state_t          state_q, state_d;
    logic [15:0]     len_q, len_d, idx_q, idx_d;
    logic [15:0]     len_full_s;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [23:0]     word_q, word_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic            cpu_rst_q, done_q, err_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    // Two-flop synchronizer plus previous sample for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Receiver next state: start recheck at half a bit, then one sample per bit period
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + CW'(1);
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_C) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == LAST_C) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == LAST_C) begin
                    rx_cnt_d     = '0;
                    rx_state_d   = RX_IDLE;
                    byte_valid_s = rx_sync_q;
                    frame_err_s  = ~rx_sync_q;
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign len_full_s = {rx_shift_q, len_q[7:0]};

    // Loader state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SYNC;
            len_q     <= 16'd0;
            idx_q     <= 16'd0;
            bcnt_q    <= 2'd0;
            word_q    <= 24'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            word_q    <= word_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= (state_q != DONE);
            done_q    <= (state_q == DONE);
            err_q     <= (state_d == ERR);
`ifdef BOOT_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Loader next state: framing, length check, little-endian word assembly
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            SYNC, ERR: begin
                if (byte_valid_s && rx_shift_q == 8'hA5) begin
                    state_d = LEN_LO;
                    idx_d   = 16'd0;
                    bcnt_d  = 2'd0;
`ifdef BOOT_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            LEN_LO: begin
                if (byte_valid_s) begin
                    len_d   = {8'd0, rx_shift_q};
                    state_d = LEN_HI;
                end else begin
                    state_d = LEN_LO;
                end
            end
            LEN_HI: begin
                if (byte_valid_s) begin
                    len_d = len_full_s;
                    if (len_full_s == 16'd0 || {16'd0, len_full_s} > MAXW_C) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = LEN_HI;
                end
            end
            DATA: begin
                if (byte_valid_s) begin
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ rx_shift_q;
`endif
                    bcnt_d = bcnt_q + 2'd1;
                    word_d = {rx_shift_q, word_q[23:8]};
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = {14'd0, idx_q, 2'b00};
                        wdata_d = {rx_shift_q, word_q};
                        idx_d   = idx_q + 16'd1;
                        if (idx_q == len_q - 16'd1) begin
`ifdef BOOT_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = DONE;
`endif
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: begin
                if (byte_valid_s) begin
                    state_d = (rx_shift_q == csum_q) ? DONE : ERR;
                end else begin
                    state_d = CHECK;
                end
            end
`endif
            DONE:    state_d = DONE;
            default: state_d = SYNC;
        endcase
        // A bad stop bit aborts any load still in progress
        if (frame_err_s && state_q != DONE) begin
            state_d = ERR;
        end else begin
            state_d = state_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign boot_done  = done_q;
    assign boot_err   = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: drives 8N1 frames at DIV=16 and checks IMEM writes and boot status.
`timescale 1ns/1ps
module tb_uart_boot_loader;
    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        cpu_rst, boot_done, boot_err;

    int tests = 0;
    int fails = 0;
    int writes_seen = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_data = 32'd0;

    uart_boot_loader #(.CLK_HZ(1_600_000), .BAUD(100_000), .IMEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .boot_done(boot_done), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the next expected one; outputs hold otherwise
    always @(negedge clk) begin
        if (!rst_n) begin
            last_addr = 32'd0;
            last_data = 32'd0;
        end else begin
            if (imem_we) begin
                writes_seen++;
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_write", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    check("write_addr", imem_addr, exp_addr_q.pop_front());
                    check("write_data", imem_wdata, exp_data_q.pop_front());
                end
                check("cpu_rst_during_write", {31'd0, cpu_rst}, 32'd1);
                last_addr = imem_addr;
                last_data = imem_wdata;
            end else begin
                check("addr_hold", imem_addr, last_addr);
                check("wdata_hold", imem_wdata, last_data);
            end
            check("done_and_cpu_rst", {31'd0, boot_done & cpu_rst}, 32'd0);
            check("done_and_err", {31'd0, boot_done & boot_err}, 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DIV);
        end
        uart_rx = stop;
        tick(DIV);
        uart_rx = 1'b1;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
        check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_done"}, {31'd0, boot_done}, 32'd0);
        check({tag, "_err"}, {31'd0, boot_err}, 32'd0);
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err);
        check({tag, "_done"}, {31'd0, boot_done}, {31'd0, done});
        check({tag, "_err"}, {31'd0, boot_err}, {31'd0, err});
        check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, ~done});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        uart_rx = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(3);
    endtask

    // Model: an image of N words yields writes of word i at byte address 4*i
    task automatic send_image(input logic [31:0] words[$], input logic bad_cs);
        logic [7:0]  cs;
        logic [15:0] n;
        cs = 8'd0;
        n  = 16'(words.size());
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int w = 0; w < words.size(); w++) begin
            exp_addr_q.push_back(32'(w) * 32'd4);
            exp_data_q.push_back(words[w]);
        end
        for (int w = 0; w < words.size(); w++) begin
            for (int k = 0; k < 4; k++) begin
                cs = cs ^ words[w][8*k +: 8];
                send_byte(words[w][8*k +: 8]);
            end
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(bad_cs ? ~cs : cs);
`else
        if (bad_cs) cs = ~cs;
`endif
        tick(4);
    endtask

    initial begin
        logic [31:0] img0[$];
        logic [31:0] img1[$];
        int base;
        img0 = '{32'h0010_0513, 32'h0000_006F};
        img1 = '{32'hEFBE_ADDE};

        tick(4);
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick(4);
        check_reset_outputs("idle");

        // Bad lengths: N=0 then N=1025; a fresh A5 clears the error
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        tick(4);
        check_flags("len0", 1'b0, 1'b1);
        send_byte(8'hA5);
        tick(2);
        check_flags("resync", 1'b0, 1'b0);
        send_byte(8'h01); send_byte(8'h04);
        tick(4);
        check_flags("len1025", 1'b0, 1'b1);
        check("len_no_writes", 32'(writes_seen), 32'd0);

        // Glitch inside DATA is ignored; bad stop bit aborts to ERR
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(2 * DIV);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        send_bits(8'hEF, 1'b0);
        tick(4);
        check_flags("frame_err", 1'b0, 1'b1);
        check("frame_err_no_writes", 32'(writes_seen), 32'd0);
        send_image(img1, 1'b0);
        check_flags("recover", 1'b1, 1'b0);
        check("recover_data", last_data, 32'hEFBE_ADDE);
        check("recover_pending", 32'(exp_addr_q.size()), 32'd0);

        // DONE ignores further traffic
        base = writes_seen;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        tick(4);
        check_flags("done_terminal", 1'b1, 1'b0);
        check("done_no_writes", 32'(writes_seen - base), 32'd0);

        // Leading junk before A5 is discarded
        do_reset();
        base = writes_seen;
        send_byte(8'h00); send_byte(8'hFF);
        send_image(img1, 1'b0);
        check_flags("junk", 1'b1, 1'b0);
        check("junk_writes", 32'(writes_seen - base), 32'd1);
        check("junk_addr", last_addr, 32'd0);
        check("junk_data", last_data, 32'hEFBE_ADDE);

`ifdef BOOT_CHECKSUM_EN
        // Wrong checksum fails, a correct reload then succeeds
        do_reset();
        send_image(img0, 1'b1);
        check_flags("bad_cs", 1'b0, 1'b1);
        send_image(img0, 1'b0);
        check_flags("good_cs", 1'b1, 1'b0);
        check("good_cs_pending", 32'(exp_addr_q.size()), 32'd0);
`endif

        // Asynchronous reset in the middle of a word, then a clean load
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05);
        uart_rx = 1'b0;
        tick(3 * DIV);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        uart_rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2 * DIV);
        check_reset_outputs("post_rst");
        base = writes_seen;
        send_image(img0, 1'b0);
        check_flags("reload", 1'b1, 1'b0);
        check("reload_writes", 32'(writes_seen - base), 32'd2);
        check("reload_addr", last_addr, 32'd4);
        check("reload_data", last_data, 32'h0000_006F);
        check("reload_pending", 32'(exp_addr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
